alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational `alu`. Performs the operations `alu` performs, plus four more, on WIDTH-bit operands.
- Adds a valid/ready handshake on both sides, two register stages and NZCV flags.
- Keeps a saturating count of completed operations.
- Sits between an operand source (sequencer or bench driver) and a result sink that may stall.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset; applies immediately, releases synchronously to clk.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- f  in  3  operation select.
- out_valid  out  1  result beat present.
- out_ready  in  1  sink accepts the result this cycle.
- y  out  WIDTH  result.
- zero  out  1  y == 0.
- neg  out  1  y[WIDTH-1].
- carry  out  1  carry out; ADD/SUB only.
- ovf  out  1  signed overflow; ADD/SUB only.
- op_count  out  CNT_W  completed-operation count.

Behaviour:
- Opcodes for f:
  - 000 AND, 001 OR, 010 ADD, 011 XOR.
  - 100 a & ~b, 101 a | ~b.
  - 110 SUB, computed as a + ~b + 1.
  - 111 SLT, signed: y = {0…, a<b}.
- Carry:
  - ADD: carry = carry out of bit WIDTH-1.
  - SUB: carry = carry out of a + ~b + 1, so 1 means no borrow (a ≥ b unsigned).
  - All other ops: carry = 0.
- Overflow:
  - ADD: ovf = (a[msb]==b[msb]) && (y[msb]!=a[msb]).
  - SUB: ovf = (a[msb]!=b[msb]) && (y[msb]!=a[msb]).
  - All other ops: ovf = 0.
  - SLT computes its subtraction internally at full width; the comparison must be correct even when a−b overflows.
- Stage S1 registers a, b, f and s1_valid.
- Stage S2 registers y, the four flags and s2_valid; it is computed from S1 through alu_core.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - out_valid = s2_valid.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no other combinational input-to-output path exists.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later when out_ready is held high.
- Throughput: 1 beat/cycle sustained.
- Stall: while out_valid && !out_ready, y and the flags hold stable.
  - S1 holds, or fills if empty.
  - in_ready drops only when both stages are full.
  - No beat is lost or duplicated.
- Simultaneous events: when S2 drains and S1 moves into S2 in the same cycle, S1 may accept a new beat in that same cycle.
- op_count:
  - +1 on each consumed result.
  - Saturates at all-ones and never wraps.
- Reset (asynchronous, any time, including mid-stall):
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - y = 0; flags zero=0, neg=0, carry=0, ovf=0.
  - op_count = 0.
  - In-flight beats are discarded.
  - in_ready = 1 from the first cycle after reset release.
- Payload registers: data and flags load only on stage advance with valid data; they need no reset beyond the values listed above.

Decomposition:
- Package alu_pkg holds:
  - the 3-bit opcode localparams (OP_AND … OP_SLT);
  - a flags struct/typedef {zero, neg, carry, ovf}.
- Sub-module alu_core: purely combinational, WIDTH-parametrised.
  - Inputs: a, b, f. Outputs: y and flags.
  - Reused by the verification reference model.

Test Plan:
- Reset and idle: hold rst_n=0 with in_valid=1, then release.
  - out_valid stays 0 throughout; y=0; op_count=0; in_ready=1 on the first cycle after release.
- Arithmetic flags, WIDTH=8, out_ready=1:
  - ADD 7F+01 → y=80, ovf=1, neg=1, carry=0, valid 2 cycles after accept.
  - ADD FF+01 → y=00, zero=1, carry=1.
  - SUB 05−07 → y=FE, carry=0, neg=1.
  - SUB 80−01 → y=7F, ovf=1.
- Logic and SLT, WIDTH=8:
  - AND F0&3C → 30.
  - f=100 F0,3C → C0.
  - XOR AA^FF → 55.
  - SLT 80,7F → 01.
  - SLT 7F,80 → 00.
  - SLT 80,01 → 01 (case where a−b overflows).
- Backpressure: stream 5 beats with out_ready=0 for cycles 3–6.
  - in_ready drops once both stages are full.
  - Results emerge in order, none dropped or duplicated.
  - op_count=5 at the end.
- Mid-stall reset: assert rst_n=0 asynchronously while out_valid=1 and out_ready=0.
  - out_valid falls immediately, without waiting for a clock edge.
  - op_count=0; the next beat after release returns correctly.
- Parameter sweep: WIDTH=32, CNT_W=2, random ops checked against alu_core.
  - op_count saturates at 3 after 4 or more results.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: result plus NZCV flags.
// Zero latency, no handshake; the pipeline wrapper owns all flow control.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             lt;
  logic [WIDTH-1:0] res;

  always_comb begin
    is_sub = (f == OP_SUB);
    b_op   = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    // Native signed compare stays correct where a-b would overflow.
    lt     = $signed(a) < $signed(b);

    res = '0;
    case (f)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = sum[WIDTH-1:0];
      OP_XOR:  res = a ^ b;
      OP_ANDN: res = a & ~b;
      OP_ORN:  res = a | ~b;
      OP_SUB:  res = sum[WIDTH-1:0];
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt};
      default: res = '0;
    endcase

    flags.zero  = (res == '0);
    flags.neg   = res[MSB];
    flags.carry = 1'b0;
    flags.ovf   = 1'b0;
    if (f == OP_ADD) begin
      flags.carry = sum[WIDTH];
      flags.ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
    end else if (f == OP_SUB) begin
      flags.carry = sum[WIDTH];
      flags.ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
    end
  end

  assign y = res;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with NZCV flags and saturating op counter; latency 2.
// Stalls hold S2 stable; in_ready falls only when both stages are full.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_q;
  logic             s2_valid_q;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f_q;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  flags_t           flags_d;
  flags_t           flags_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (a_q),
    .b     (b_q),
    .f     (f_q),
    .y     (y_d),
    .flags (flags_d)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Operand stage carries no reset: it is only observed behind s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      a_q <= a;
      b_q <= b;
      f_q <= f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      flags_q    <= '0;
      cnt_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          y_q     <= y_d;
          flags_q <= flags_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random checks of alu_pipe at WIDTH=8 and WIDTH=32/CNT_W=2.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  fl;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic        in_ready8, out_valid8, zero8, neg8, carry8, ovf8;
  logic [7:0]  a8 = '0, b8 = '0, y8;
  logic [2:0]  f8 = '0;
  logic [15:0] op_count8;

  logic        in_valid32 = 1'b0, out_ready32 = 1'b1;
  logic        in_ready32, out_valid32, zero32, neg32, carry32, ovf32;
  logic [31:0] a32 = '0, b32 = '0, y32;
  logic [2:0]  f32 = '0;
  logic [1:0]  op_count32;

  int   checks = 0, errors = 0, cyc = 0;
  exp_t q8[$], q32[$];
  logic [7:0]  exp8_y;
  logic [3:0]  exp8_fl;
  logic [31:0] exp32_y;
  logic [3:0]  exp32_fl;
  bit   lat_chk = 0, acc8 = 0, acc32 = 0, ir8_s = 0;
  logic [7:0]  y8_s;
  logic [3:0]  fl8_s;
  int   cnt8 = 0, cnt32 = 0, ncons32 = 0;

  alu_pipe #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .f(f8), .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .zero(zero8), .neg(neg8), .carry(carry8), .ovf(ovf8), .op_count(op_count8)
  );

  alu_pipe #(.WIDTH(32), .CNT_W(2)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .f(f32), .out_valid(out_valid32), .out_ready(out_ready32),
    .y(y32), .zero(zero32), .neg(neg32), .carry(carry32), .ovf(ovf32), .op_count(op_count32)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Independent reference: flags derived from wide signed/unsigned arithmetic.
  function automatic logic [35:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    logic [31:0] y;
    logic        c, v;
    longint      sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; r = 0;
    case (f)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd3: y = a ^ b;
      3'd4: y = a & ~b;
      3'd5: y = a | ~b;
      3'd2: begin
        y = a + b;
        c = ({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF;
        r = sa + sb;
        v = (r != longint'($signed(y)));
      end
      3'd6: begin
        y = a - b;
        c = (a >= b);
        r = sa - sb;
        v = (r != longint'($signed(y)));
      end
      default: y = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    return {(y == 32'd0), y[31], c, v, y};
  endfunction

  task automatic monitor();
    exp_t e;
    acc8 = 0;
    acc32 = 0;
    ir8_s = in_ready8;
    y8_s = y8;
    fl8_s = {zero8, neg8, carry8, ovf8};
    if (rst_n) begin
      chk("op_count8", 64'(op_count8), 64'(cnt8));
      chk("op_count32", 64'(op_count32), 64'(cnt32));
      if (out_valid8 && out_ready8) begin
        chk("sb8_nonempty", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("y8", 64'(y8), 64'(e.y[7:0]));
          chk("flags8", 64'({zero8, neg8, carry8, ovf8}), 64'(e.fl));
          if (e.lat) chk("latency8", 64'(cyc - e.acc), 64'd2);
        end
        if (cnt8 < 65535) cnt8++;
      end
      if (out_valid32 && out_ready32) begin
        chk("sb32_nonempty", 64'(q32.size() > 0), 64'd1);
        if (q32.size() > 0) begin
          e = q32.pop_front();
          chk("y32", 64'(y32), 64'(e.y));
          chk("flags32", 64'({zero32, neg32, carry32, ovf32}), 64'(e.fl));
        end
        if (cnt32 < 3) cnt32++;
        ncons32++;
      end
      if (in_valid8 && in_ready8) begin
        acc8 = 1;
        q8.push_back('{y: {24'h0, exp8_y}, fl: exp8_fl, acc: cyc, lat: lat_chk});
      end
      if (in_valid32 && in_ready32) begin
        acc32 = 1;
        q32.push_back('{y: exp32_y, fl: exp32_fl, acc: cyc, lat: 1'b0});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] y, input logic [3:0] fl);
    in_valid8 = 1'b1; f8 = f; a8 = a; b8 = b; exp8_y = y; exp8_fl = fl;
    tick();
    chk("accept8", 64'(acc8), 64'd1);
  endtask

  task automatic drain8();
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    for (int i = 0; i < 20; i++) if (q8.size() != 0) tick();
    chk("drain8", 64'(q8.size()), 64'd0);
  endtask

  initial begin
    exp8_y = '0; exp8_fl = '0; exp32_y = '0; exp32_fl = '0;
    // Reset held with a beat offered: nothing may come out.
    in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; f8 = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", 64'(out_valid8), 64'd0);
      chk("rst_y", 64'(y8), 64'd0);
      chk("rst_flags", 64'({zero8, neg8, carry8, ovf8}), 64'd0);
      chk("rst_op_count", 64'(op_count8), 64'd0);
    end
    rst_n = 1'b1;
    in_valid8 = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready8), 64'd1);

    // Arithmetic and logic, out_ready held high; flags are {z,n,c,v}.
    lat_chk = 1;
    send8(OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b0101);
    send8(OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b1010);
    send8(OP_SUB,  8'h05, 8'h07, 8'hFE, 4'b0100);
    send8(OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0011);
    send8(OP_ADD,  8'h80, 8'h80, 8'h00, 4'b1011);
    send8(OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000);
    send8(OP_ANDN, 8'hF0, 8'h3C, 8'hC0, 4'b0100);
    send8(OP_XOR,  8'hAA, 8'hFF, 8'h55, 4'b0000);
    send8(OP_OR,   8'h0F, 8'h30, 8'h3F, 4'b0000);
    send8(OP_ORN,  8'hA0, 8'h0F, 8'hF0, 4'b0100);
    send8(OP_SLT,  8'h80, 8'h7F, 8'h01, 4'b0000);
    send8(OP_SLT,  8'h7F, 8'h80, 8'h00, 4'b1000);
    send8(OP_SLT,  8'h80, 8'h01, 8'h01, 4'b0000);
    send8(OP_SUB,  8'h07, 8'h07, 8'h00, 4'b1010);
    drain8();
    lat_chk = 0;

    // Fresh counter before the backpressure stream.
    rst_n = 1'b0;
    tick();
    q8.delete(); cnt8 = 0;
    rst_n = 1'b1;

    begin
      int sent = 0;
      for (int c = 0; c < 12; c++) begin
        out_ready8 = !(c >= 3 && c <= 6);
        in_valid8 = (sent < 5);
        f8 = OP_ADD; a8 = 8'(sent * 16 + 1); b8 = 8'h03;
        exp8_y = 8'(sent * 16 + 4); exp8_fl = 4'b0000;
        tick();
        if (acc8) sent++;
        if (c >= 3 && c <= 6) begin
          chk("bp_in_ready_low", 64'(ir8_s), 64'd0);
          chk("bp_y_hold", 64'(y8_s), 64'h14);
          chk("bp_flags_hold", 64'(fl8_s), 64'd0);
        end
      end
      chk("bp_sent", 64'(sent), 64'd5);
    end
    drain8();
    chk("bp_op_count", 64'(op_count8), 64'd5);

    // Asynchronous reset while a result is stalled at the output.
    out_ready8 = 1'b0;
    send8(OP_ADD, 8'h10, 8'h20, 8'h30, 4'b0000);
    in_valid8 = 1'b0;
    tick();
    chk("stall_out_valid", 64'(out_valid8), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid8), 64'd0);
    chk("async_rst_op_count", 64'(op_count8), 64'd0);
    chk("async_rst_y", 64'(y8), 64'd0);
    q8.delete(); cnt8 = 0; cnt32 = 0;
    out_ready8 = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_midrst", 64'(in_ready8), 64'd1);
    send8(OP_SUB, 8'h09, 8'h03, 8'h06, 4'b0010);
    drain8();

    // WIDTH=32 random sweep with random backpressure.
    begin
      bit has_beat = 0;
      logic [35:0] m;
      for (int c = 0; c < 120; c++) begin
        if (!has_beat && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 3))
            0: a32 = 32'h8000_0000;
            1: a32 = 32'h7FFF_FFFF;
            default: a32 = $urandom;
          endcase
          case ($urandom_range(0, 3))
            0: b32 = 32'h8000_0000;
            1: b32 = 32'h0000_0001;
            default: b32 = $urandom;
          endcase
          f32 = 3'($urandom_range(0, 7));
          m = model32(a32, b32, f32);
          exp32_y = m[31:0];
          exp32_fl = m[35:32];
          has_beat = 1;
        end
        in_valid32 = has_beat;
        out_ready32 = ($urandom_range(0, 3) != 0);
        tick();
        if (acc32) has_beat = 0;
      end
      in_valid32 = 1'b0;
      out_ready32 = 1'b1;
      for (int i = 0; i < 20; i++) if (q32.size() != 0) tick();
      chk("drain32", 64'(q32.size()), 64'd0);
      chk("sweep_enough", 64'(ncons32 >= 4), 64'd1);
      chk("op_count32_sat", 64'(op_count32), 64'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
